// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC decimator sequencer.
// Provides the FSM state encoding and the counter-width helper used by the
// top level. No ports; imported by cic_decim_ctrl.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PRIME = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    // Bits needed for an unsigned counter that must be able to hold 'limit'.
    function automatic int cnt_width(input int limit);
        if (limit < 2) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cic_ctrl_fifo.sv
// 2-entry synchronous FIFO holding decimated samples for the downstream consumer.
// Latency: a push is visible on dout/empty the cycle after it is accepted.
// Backpressure: push while full without a same-cycle pop is dropped and pulses ovf.
// Ports: clk, rst (sync, active-high), push/din, pop, flush (empties, overrides push/pop),
//        dout (head), full, empty, ovf (combinational drop pulse).
module cic_ctrl_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         ovf
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_pop  = pop && !empty && !flush;
    // When full, a same-cycle pop frees the head slot, so the push is accepted.
    assign do_push = push && !flush && (!full || do_pop);
    assign ovf     = push && !flush && full && !do_pop;
    // Tail slot: rd + count, mod 2 (count of 2 maps back onto rd).
    assign wr_ptr  = rd_q ^ cnt_q[0];
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for a 4-stage CIC decimator: clear, settle, then capture samples into a 2-entry buffer.
// Latency: sample captured CAPTURE_DLY cycles after its strobe, on m_valid one cycle later.
// Backpressure: m_valid/m_ready; capture into a full buffer without a pop drops the sample, sets err_ovf.
// Ports: clk, rst (sync, active-high); cfg_start/cfg_stop/err_clr control pulses;
//        in_valid -> cic_en; cic_arst_n (registered CIC clear); cic_data_clk/cic_data_out from CIC;
//        m_data/m_valid/m_ready output stream; running; sticky err_ovf, err_timeout.
// Optional: define CIC_CTRL_OVF_CNT_EN to add ovf_count[15:0], a saturating dropped-sample count.
module cic_decim_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH_O   = 16,
    parameter int CLR_CYCLES     = 4,
    parameter int SETTLE_SAMPLES = 4,
    parameter int CAPTURE_DLY    = 1,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic                    err_clr,
    input  logic                    in_valid,
    output logic                    cic_en,
    output logic                    cic_arst_n,
    input  logic                    cic_data_clk,
    input  logic [DATA_WIDTH_O-1:0] cic_data_out,
    output logic [DATA_WIDTH_O-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    running,
    output logic                    err_ovf,
    output logic                    err_timeout
`ifdef CIC_CTRL_OVF_CNT_EN
    ,
    output logic [15:0]             ovf_count
`endif
);

    localparam int CLR_W  = cnt_width(CLR_CYCLES);
    localparam int SET_W  = cnt_width(SETTLE_SAMPLES);
    localparam int WDOG_W = cnt_width(WDOG_CYCLES);
    localparam int DLY_W  = (CAPTURE_DLY > 0) ? CAPTURE_DLY : 1;

    state_e            state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic              cic_arst_n_q, cic_arst_n_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_to_q, err_to_d;
    logic              strobe_run;
    logic              capture;
    logic              push;
    logic              flush;
    logic              wdog_active;
    logic              to_set;
    logic              fifo_ovf;
    logic              fifo_full;
    logic              fifo_empty;

    // Only strobes seen while already in RUN enter the capture delay line,
    // so the final settling strobe (seen in PRIME) is never captured.
    assign strobe_run = cic_data_clk && (state_q == ST_RUN);
    assign capture    = (CAPTURE_DLY == 0) ? strobe_run : dly_q[DLY_W-1];
    assign push       = capture && (state_q == ST_RUN) && !cfg_start && !cfg_stop;
    assign flush      = cfg_start || cfg_stop || (state_q == ST_CLEAR);

    assign wdog_active = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && !cfg_start && !cfg_stop;
    assign to_set      = wdog_active && !cic_data_clk && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        clr_cnt_d = clr_cnt_q;
        settle_d = settle_q;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                    state_d = ST_PRIME;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            ST_PRIME: begin
                if (cic_data_clk) begin
                    if (settle_q == SET_W'(SETTLE_SAMPLES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
            end
            default: state_d = state_q;
        endcase

        if (cfg_start) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            settle_d  = '0;
        end
        if (cfg_stop) begin
            state_d = ST_IDLE;
        end

        cic_arst_n_d = (state_d == ST_PRIME) || (state_d == ST_RUN);

        dly_d[0] = strobe_run;
        for (int i = 1; i < DLY_W; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        if (cfg_start || cfg_stop) begin
            dly_d = '0;
        end

        wdog_d = '0;
        if (wdog_active && !cic_data_clk) begin
            wdog_d = (wdog_q == WDOG_W'(WDOG_CYCLES)) ? wdog_q : wdog_q + WDOG_W'(1);
        end

        // Set events take priority over clearing in the same cycle.
        err_ovf_d = (err_clr || cfg_start) ? 1'b0 : err_ovf_q;
        if (fifo_ovf) begin
            err_ovf_d = 1'b1;
        end
        err_to_d = (err_clr || cfg_start) ? 1'b0 : err_to_q;
        if (to_set) begin
            err_to_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            settle_q     <= '0;
            wdog_q       <= '0;
            dly_q        <= '0;
            cic_arst_n_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_q     <= settle_d;
            wdog_q       <= wdog_d;
            dly_q        <= dly_d;
            cic_arst_n_q <= cic_arst_n_d;
            err_ovf_q    <= err_ovf_d;
            err_to_q     <= err_to_d;
        end
    end

    cic_ctrl_fifo #(
        .W(DATA_WIDTH_O)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (cic_data_out),
        .pop  (m_ready),
        .flush(flush),
        .dout (m_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .ovf  (fifo_ovf)
    );

`ifdef CIC_CTRL_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = (err_clr || cfg_start) ? 16'd0 : ovf_cnt_q;
        if (fifo_ovf && (ovf_cnt_d != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= 16'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    // Input enable follows the ADC valid directly once the CIC is out of clear.
    assign cic_en      = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && in_valid;
    assign cic_arst_n  = cic_arst_n_q;
    assign m_valid     = !fifo_empty;
    assign running     = (state_q == ST_RUN);
    assign err_ovf     = err_ovf_q;
    assign err_timeout = err_to_q;

endmodule
